decode_issue_stage: RTL and testbench
=====================================

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/operand data width.
REQ-002 Parameter NUM_WR_PORTS, default 2, register-file write ports (legal 1..4).
REQ-003 Parameter LOAD_USE_STALL_CYCLES, default 1, bubbles inserted per load-use hazard (legal 1..3).
REQ-004 Parameter LOAD_OPCODE, default 6'h23; STORE_OPCODE, default 6'h2B.
REQ-005 One clock; reset asynchronous, active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-006 if_valid_in input 1; instruction_in input 32, fetched instruction, held stable by fetch while rd_inst_ena_out=0.
REQ-007 reg_wr_addr_in input 5*NUM_WR_PORTS; reg_wr_data_in input DATA_WIDTH*NUM_WR_PORTS; reg_wr_en_in input NUM_WR_PORTS; port k occupies slice k.
REQ-008 ex_ready_in input 1, EX accepts ID/EX contents; flush_in input 1, branch/jump taken, kill decode.
REQ-009 rd_inst_ena_out output 1, fetch may advance; stall_out output 1, load-use stall active.
REQ-010 ID/EX outputs (registered): id_valid_out 1; opcode_out 6; inst_function_out 6; data_alu_a_out DATA_WIDTH; data_alu_b_out DATA_WIDTH; constant_out DATA_WIDTH; imm_inst_out 1; reg_wr_addr_out 5; reg_wr_en_out 1; mem_data_rd_en_out 1; mem_data_wr_en_out 1.

Function
REQ-011 Fields: opcode [31:26], rs1 [25:21], rs2 [20:16], rd [15:11], function [5:0], immediate [15:0] sign-extended to DATA_WIDTH.
REQ-012 opcode 0 (R-type): reads rs1, rs2; writes rd; imm_inst=0.
REQ-013 LOAD_OPCODE: reads rs1; writes rs2 field; mem_data_rd_en=1; imm_inst=1.
REQ-014 STORE_OPCODE: reads rs1, rs2; no write; mem_data_wr_en=1; imm_inst=1.
REQ-015 Any other opcode (I-type): reads rs1; writes rs2 field; imm_inst=1.
REQ-016 reg_wr_en SHALL be 0 whenever destination address is 0.
REQ-017 Register file: 32 x DATA_WIDTH; register 0 reads 0, writes ignored; written at rising clk.
REQ-018 Same-address simultaneous writes: highest port index wins.
REQ-019 Read bypass: a read whose address matches an enabled write port in the same cycle returns that port's data (highest index), except address 0.
REQ-020 Load-use hazard: id_valid_out=1 and mem_data_rd_en_out=1 and reg_wr_addr_out nonzero and equal to a source register actually read by the decoding valid instruction.
REQ-021 Stall FSM states IDLE, STALL; 2-bit counter stall_cnt.
REQ-022 IDLE + hazard: stall_out=1, bubble into ID/EX, stall_cnt<=LOAD_USE_STALL_CYCLES-1, next STALL if that value nonzero else IDLE.
REQ-023 STALL: stall_out=1, bubble into ID/EX, stall_cnt decrements, return to IDLE when stall_cnt=1 at edge; total bubbles = LOAD_USE_STALL_CYCLES.
REQ-024 Priority per cycle: flush_in > ex_ready_in=0 > stall > normal issue.
REQ-025 flush_in=1: id_valid_out<=0 and all control outputs <=0, FSM<=IDLE, stall_cnt<=0, rd_inst_ena_out=1, regardless of ex_ready_in.
REQ-026 ex_ready_in=0 (no flush): ID/EX, FSM, counter hold; rd_inst_ena_out=0.
REQ-027 Normal issue: ID/EX loads decoded instruction, id_valid_out<=if_valid_in; rd_inst_ena_out=1.
REQ-028 rd_inst_ena_out = !(stall_out) & (ex_ready_in | flush_in); combinational.
REQ-029 Bubble: id_valid_out=0, reg_wr_en_out=0, mem_data_rd_en_out=0, mem_data_wr_en_out=0; data fields don't-care.
REQ-030 if_valid_in=0: no hazard evaluated, bubble issued.

Reset
REQ-031 rst_n low asynchronously clears all ID/EX outputs, all 32 registers, FSM to IDLE, stall_cnt to 0.
REQ-032 Reset mid-stall aborts the stall; first post-reset cycle issues normally.

Verification
REQ-033 Write r5=0xA5A5 via port 1, r5=0x1111 via port 0 same cycle; next decode ADD r5,r5 -> data_alu_a_out=data_alu_b_out=0xA5A5.
REQ-034 Write r7=0x42 while decoding instruction reading r7 same cycle -> data_alu_a_out=0x42 next cycle (bypass).
REQ-035 LOAD r3 then ADD r4,r3,r1 with LOAD_USE_STALL_CYCLES=2 -> stall_out=1 for 2 cycles, two bubbles, ADD issues cycle 3; LOAD r0 then use r0 -> no stall.
REQ-036 flush_in during STALL with ex_ready_in=0 -> id_valid_out=0 next cycle, stall_out=0, FSM IDLE.
REQ-037 ex_ready_in=0 for 3 cycles with valid ADD in ID/EX -> outputs unchanged, rd_inst_ena_out=0; rst_n pulse mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: field decode, 32-entry register file with same-cycle
// write bypass, load-use hazard detection and a registered ID/EX boundary.
module decode_issue_stage #(
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned NUM_WR_PORTS          = 2,
    parameter int unsigned LOAD_USE_STALL_CYCLES = 1,
    parameter logic [5:0]  LOAD_OPCODE           = 6'h23,
    parameter logic [5:0]  STORE_OPCODE          = 6'h2B
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               if_valid_in,
    input  logic [31:0]                        instruction_in,
    input  logic [5*NUM_WR_PORTS-1:0]          reg_wr_addr_in,
    input  logic [DATA_WIDTH*NUM_WR_PORTS-1:0] reg_wr_data_in,
    input  logic [NUM_WR_PORTS-1:0]            reg_wr_en_in,
    input  logic                               ex_ready_in,
    input  logic                               flush_in,
    output logic                               rd_inst_ena_out,
    output logic                               stall_out,
    output logic                               id_valid_out,
    output logic [5:0]                         opcode_out,
    output logic [5:0]                         inst_function_out,
    output logic [DATA_WIDTH-1:0]              data_alu_a_out,
    output logic [DATA_WIDTH-1:0]              data_alu_b_out,
    output logic [DATA_WIDTH-1:0]              constant_out,
    output logic                               imm_inst_out,
    output logic [4:0]                         reg_wr_addr_out,
    output logic                               reg_wr_en_out,
    output logic                               mem_data_rd_en_out,
    output logic                               mem_data_wr_en_out
);

    localparam logic [1:0] StallInit = 2'(LOAD_USE_STALL_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    typedef struct packed {
        logic                  valid;
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic [DATA_WIDTH-1:0] alu_a;
        logic [DATA_WIDTH-1:0] alu_b;
        logic [DATA_WIDTH-1:0] constant;
        logic                  imm;
        logic [4:0]            wr_addr;
        logic                  wr_en;
        logic                  mem_rd;
        logic                  mem_wr;
    } idex_t;

    state_e                state_q, state_d;
    logic [1:0]            stall_cnt_q, stall_cnt_d;
    idex_t                 idex_q, idex_d, dec;
    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
    logic [4:0]            rs1, rs2, rd;
    logic [5:0]            opcode;
    logic                  is_rtype, is_load, is_store, reads_rs2, hazard;
    logic                  unused_shamt;

    assign opcode       = instruction_in[31:26];
    assign rs1          = instruction_in[25:21];
    assign rs2          = instruction_in[20:16];
    assign rd           = instruction_in[15:11];
    assign unused_shamt = ^instruction_in[10:6];
    assign is_rtype     = (opcode == 6'h00);
    assign is_load      = (opcode == LOAD_OPCODE);
    assign is_store     = (opcode == STORE_OPCODE);
    assign reads_rs2    = is_rtype | is_store;

    // Register-file writes in ascending port order so the highest port wins.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (reg_wr_en_in[k]) begin
                regs_d[reg_wr_addr_in[5*k +: 5]] = reg_wr_data_in[DATA_WIDTH*k +: DATA_WIDTH];
            end
        end
        regs_d[0] = '0;
    end

    // Operand read with same-cycle bypass from the write ports (highest port wins).
    always_comb begin
        rs1_data = regs_q[rs1];
        rs2_data = regs_q[rs2];
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (reg_wr_en_in[k] && reg_wr_addr_in[5*k +: 5] == rs1) begin
                rs1_data = reg_wr_data_in[DATA_WIDTH*k +: DATA_WIDTH];
            end
            if (reg_wr_en_in[k] && reg_wr_addr_in[5*k +: 5] == rs2) begin
                rs2_data = reg_wr_data_in[DATA_WIDTH*k +: DATA_WIDTH];
            end
        end
        if (rs1 == 5'd0) rs1_data = '0;
        if (rs2 == 5'd0) rs2_data = '0;
    end

    // Instruction decode into the ID/EX bundle.
    always_comb begin
        dec          = '0;
        dec.valid    = if_valid_in;
        dec.opcode   = opcode;
        dec.funct    = instruction_in[5:0];
        dec.alu_a    = rs1_data;
        dec.alu_b    = rs2_data;
        dec.constant = {{(DATA_WIDTH-16){instruction_in[15]}}, instruction_in[15:0]};
        dec.imm      = !is_rtype;
        dec.wr_addr  = is_rtype ? rd : (is_store ? 5'd0 : rs2);
        dec.wr_en    = !is_store && (dec.wr_addr != 5'd0);
        dec.mem_rd   = is_load;
        dec.mem_wr   = is_store;
    end

    // Load-use hazard against the load currently sitting in ID/EX.
    assign hazard = if_valid_in && idex_q.valid && idex_q.mem_rd && (idex_q.wr_addr != 5'd0) &&
                    ((idex_q.wr_addr == rs1) || (reads_rs2 && idex_q.wr_addr == rs2));

    assign stall_out       = !flush_in && ((state_q == StStall) || hazard);
    assign rd_inst_ena_out = !stall_out && (ex_ready_in || flush_in);

    // Next-state for the stall FSM and ID/EX: flush > EX backpressure > stall > issue.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        idex_d      = idex_q;
        if (flush_in) begin
            state_d     = StIdle;
            stall_cnt_d = 2'd0;
            idex_d      = '0;
        end else if (!ex_ready_in) begin
            // hold everything
        end else if (stall_out) begin
            idex_d        = dec;
            idex_d.valid  = 1'b0;
            idex_d.wr_en  = 1'b0;
            idex_d.mem_rd = 1'b0;
            idex_d.mem_wr = 1'b0;
            if (state_q == StIdle) begin
                stall_cnt_d = StallInit;
                state_d     = (StallInit != 2'd0) ? StStall : StIdle;
            end else begin
                stall_cnt_d = stall_cnt_q - 2'd1;
                state_d     = (stall_cnt_q == 2'd1) ? StIdle : StStall;
            end
        end else begin
            idex_d = dec;
            if (!if_valid_in) begin
                idex_d.wr_en  = 1'b0;
                idex_d.mem_rd = 1'b0;
                idex_d.mem_wr = 1'b0;
            end
        end
    end

    // State, ID/EX and register-file storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stall_cnt_q <= 2'd0;
            idex_q      <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            idex_q      <= idex_d;
            regs_q      <= regs_d;
        end
    end

    assign id_valid_out       = idex_q.valid;
    assign opcode_out         = idex_q.opcode;
    assign inst_function_out  = idex_q.funct;
    assign data_alu_a_out     = idex_q.alu_a;
    assign data_alu_b_out     = idex_q.alu_b;
    assign constant_out       = idex_q.constant;
    assign imm_inst_out       = idex_q.imm;
    assign reg_wr_addr_out    = idex_q.wr_addr;
    assign reg_wr_en_out      = idex_q.wr_en;
    assign mem_data_rd_en_out = idex_q.mem_rd;
    assign mem_data_wr_en_out = idex_q.mem_wr;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage (2 write ports, 2-cycle load-use stall).
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_in;
    logic [31:0] instruction_in;
    logic [9:0]  reg_wr_addr_in;
    logic [63:0] reg_wr_data_in;
    logic [1:0]  reg_wr_en_in;
    logic        ex_ready_in, flush_in;
    logic        rd_inst_ena_out, stall_out, id_valid_out;
    logic [5:0]  opcode_out, inst_function_out;
    logic [31:0] data_alu_a_out, data_alu_b_out, constant_out;
    logic        imm_inst_out, reg_wr_en_out, mem_data_rd_en_out, mem_data_wr_en_out;
    logic [4:0]  reg_wr_addr_out;

    int n_checks = 0;
    int n_fail   = 0;

    decode_issue_stage #(
        .DATA_WIDTH(32),
        .NUM_WR_PORTS(2),
        .LOAD_USE_STALL_CYCLES(2),
        .LOAD_OPCODE(6'h23),
        .STORE_OPCODE(6'h2B)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid_in(if_valid_in), .instruction_in(instruction_in),
        .reg_wr_addr_in(reg_wr_addr_in), .reg_wr_data_in(reg_wr_data_in),
        .reg_wr_en_in(reg_wr_en_in), .ex_ready_in(ex_ready_in), .flush_in(flush_in),
        .rd_inst_ena_out(rd_inst_ena_out), .stall_out(stall_out),
        .id_valid_out(id_valid_out), .opcode_out(opcode_out),
        .inst_function_out(inst_function_out), .data_alu_a_out(data_alu_a_out),
        .data_alu_b_out(data_alu_b_out), .constant_out(constant_out),
        .imm_inst_out(imm_inst_out), .reg_wr_addr_out(reg_wr_addr_out),
        .reg_wr_en_out(reg_wr_en_out), .mem_data_rd_en_out(mem_data_rd_en_out),
        .mem_data_wr_en_out(mem_data_wr_en_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2);
        return {6'h00, s1, s2, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] s1,
                                         input logic [4:0] t, input logic [15:0] imm);
        return {op, s1, t, imm};
    endfunction

    initial begin
        rst_n = 1'b0; if_valid_in = 1'b0; instruction_in = '0;
        reg_wr_addr_in = '0; reg_wr_data_in = '0; reg_wr_en_in = '0;
        ex_ready_in = 1'b0; flush_in = 1'b0;
        tick(); tick();
        check_eq("rst_valid", {63'd0, id_valid_out}, 64'd0);
        check_eq("rst_alu_a", {32'd0, data_alu_a_out}, 64'd0);
        check_eq("rst_wr_en", {63'd0, reg_wr_en_out}, 64'd0);
        check_eq("rst_stall", {63'd0, stall_out}, 64'd0);
        rst_n = 1'b1; ex_ready_in = 1'b1;

        // Same-address writes: port 1 must win.
        reg_wr_addr_in = {5'd5, 5'd5};
        reg_wr_data_in = {32'h0000_A5A5, 32'h0000_1111};
        reg_wr_en_in   = 2'b11;
        tick();
        reg_wr_en_in = 2'b00;
        if_valid_in = 1'b1; instruction_in = r_add(5'd6, 5'd5, 5'd5);
        tick();
        check_eq("prio_a", {32'd0, data_alu_a_out}, 64'hA5A5);
        check_eq("prio_b", {32'd0, data_alu_b_out}, 64'hA5A5);
        check_eq("add_valid", {63'd0, id_valid_out}, 64'd1);
        check_eq("add_wr_addr", {59'd0, reg_wr_addr_out}, 64'd6);
        check_eq("add_wr_en", {63'd0, reg_wr_en_out}, 64'd1);
        check_eq("add_imm", {63'd0, imm_inst_out}, 64'd0);
        check_eq("add_funct", {58'd0, inst_function_out}, 64'h20);

        // Same-cycle bypass of r7.
        reg_wr_addr_in = {5'd0, 5'd7}; reg_wr_data_in = {32'd0, 32'h42}; reg_wr_en_in = 2'b01;
        instruction_in = r_add(5'd8, 5'd7, 5'd0);
        tick();
        check_eq("bypass_a", {32'd0, data_alu_a_out}, 64'h42);
        check_eq("r0_b", {32'd0, data_alu_b_out}, 64'd0);
        reg_wr_en_in = 2'b00;

        // I-type with negative immediate.
        instruction_in = i_op(6'h08, 5'd7, 5'd9, 16'hFFF0);
        tick();
        check_eq("itype_const", {32'd0, constant_out}, 64'hFFFF_FFF0);
        check_eq("itype_imm", {63'd0, imm_inst_out}, 64'd1);
        check_eq("itype_wr_addr", {59'd0, reg_wr_addr_out}, 64'd9);
        check_eq("itype_a", {32'd0, data_alu_a_out}, 64'h42);

        // I-type targeting r0: no write.
        instruction_in = i_op(6'h08, 5'd7, 5'd0, 16'h0001);
        tick();
        check_eq("r0_dest_wr_en", {63'd0, reg_wr_en_out}, 64'd0);
        check_eq("r0_dest_valid", {63'd0, id_valid_out}, 64'd1);

        // Store.
        instruction_in = i_op(6'h2B, 5'd7, 5'd5, 16'h0004);
        tick();
        check_eq("st_wr_en", {63'd0, reg_wr_en_out}, 64'd0);
        check_eq("st_mem_wr", {63'd0, mem_data_wr_en_out}, 64'd1);
        check_eq("st_b", {32'd0, data_alu_b_out}, 64'hA5A5);

        // Load-use hazard, two bubbles.
        instruction_in = i_op(6'h23, 5'd1, 5'd3, 16'h0000);
        tick();
        check_eq("ld_mem_rd", {63'd0, mem_data_rd_en_out}, 64'd1);
        check_eq("ld_wr_addr", {59'd0, reg_wr_addr_out}, 64'd3);
        instruction_in = r_add(5'd4, 5'd3, 5'd1);
        #1;
        check_eq("lu_stall0", {63'd0, stall_out}, 64'd1);
        check_eq("lu_ena0", {63'd0, rd_inst_ena_out}, 64'd0);
        tick();
        check_eq("lu_bubble1", {63'd0, id_valid_out}, 64'd0);
        check_eq("lu_stall1", {63'd0, stall_out}, 64'd1);
        tick();
        check_eq("lu_bubble2", {63'd0, id_valid_out}, 64'd0);
        check_eq("lu_stall2", {63'd0, stall_out}, 64'd0);
        check_eq("lu_ena2", {63'd0, rd_inst_ena_out}, 64'd1);
        tick();
        check_eq("lu_issue", {63'd0, id_valid_out}, 64'd1);
        check_eq("lu_issue_addr", {59'd0, reg_wr_addr_out}, 64'd4);

        // Load to r0 never stalls.
        instruction_in = i_op(6'h23, 5'd1, 5'd0, 16'h0000);
        tick();
        check_eq("ld0_wr_en", {63'd0, reg_wr_en_out}, 64'd0);
        instruction_in = r_add(5'd4, 5'd0, 5'd0);
        #1;
        check_eq("ld0_no_stall", {63'd0, stall_out}, 64'd0);
        tick();
        check_eq("ld0_issue", {63'd0, id_valid_out}, 64'd1);

        // Flush during STALL with EX not ready.
        instruction_in = i_op(6'h23, 5'd1, 5'd3, 16'h0000);
        tick();
        instruction_in = r_add(5'd4, 5'd3, 5'd1);
        tick();
        check_eq("fl_in_stall", {63'd0, stall_out}, 64'd1);
        ex_ready_in = 1'b0; flush_in = 1'b1;
        #1;
        check_eq("fl_ena", {63'd0, rd_inst_ena_out}, 64'd1);
        tick();
        flush_in = 1'b0; ex_ready_in = 1'b1; if_valid_in = 1'b0;
        #1;
        check_eq("fl_valid", {63'd0, id_valid_out}, 64'd0);
        check_eq("fl_stall", {63'd0, stall_out}, 64'd0);
        if_valid_in = 1'b1; instruction_in = r_add(5'd6, 5'd5, 5'd5);
        tick();
        check_eq("fl_idle_issue", {63'd0, id_valid_out}, 64'd1);

        // EX backpressure holds ID/EX.
        ex_ready_in = 1'b0; instruction_in = i_op(6'h23, 5'd1, 5'd3, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_ena", {63'd0, rd_inst_ena_out}, 64'd0);
            tick();
            check_eq("hold_valid", {63'd0, id_valid_out}, 64'd1);
            check_eq("hold_addr", {59'd0, reg_wr_addr_out}, 64'd6);
            check_eq("hold_a", {32'd0, data_alu_a_out}, 64'hA5A5);
        end

        // Asynchronous reset mid-hold.
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, id_valid_out}, 64'd0);
        check_eq("arst_a", {32'd0, data_alu_a_out}, 64'd0);
        check_eq("arst_addr", {59'd0, reg_wr_addr_out}, 64'd0);
        rst_n = 1'b1; ex_ready_in = 1'b1; instruction_in = r_add(5'd6, 5'd5, 5'd5);
        tick();
        check_eq("post_rst_issue", {63'd0, id_valid_out}, 64'd1);
        check_eq("post_rst_rf", {32'd0, data_alu_a_out}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
